gate_ctrl: RTL and testbench

//  Responder side of the gate enable/sync handshake driven by the startup sequencer.
//  - Each channel accepts a gate enable request.
//  - It drives the power switch for that gate and waits for the ramp to settle.
//  - When settled, it raises gate sync. The sequencer's gate_sync_i is connected to this sync output.
//  - Handles ramp-down, power-good timeout and fault latching per channel.
//  - Sits between the startup sequencer and the analog power-gate switches.
//

---
 rtl/gate_ctrl_pkg.sv | 19 +
 rtl/gate_ctrl_ch.sv | 132 +++++++++++++
 rtl/gate_ctrl.sv | 42 ++++
 tb/tb_gate_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_ctrl_pkg.sv
// Shared types and default timing constants for the power-gate channel controller.
// Imported by gate_ctrl and gate_ctrl_ch.
`timescale 1ns/1ps
package gate_ctrl_pkg;

  typedef enum logic [2:0] {
    OFF,
    RAMP_UP,
    ON,
    RAMP_DN,
    FAULT
  } gate_state_t;

  localparam int unsigned DEF_N_CH    = 5;
  localparam int unsigned DEF_ON_DLY  = 16;
  localparam int unsigned DEF_OFF_DLY = 8;
  localparam int unsigned DEF_TIMEOUT = 64;

endpackage

// File: rtl/gate_ctrl_ch.sv
// One power-gate channel: pg synchronizer, ramp counter and enable/sync FSM.
// Ports: clk_i, rst_i, en_i, pg_i (async) -> pwr_o, sync_o, busy_o, fault_o.
`timescale 1ns/1ps
module gate_ctrl_ch
  import gate_ctrl_pkg::*;
#(
  parameter int unsigned ON_DLY  = DEF_ON_DLY,
  parameter int unsigned OFF_DLY = DEF_OFF_DLY,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic pg_i,
  output logic pwr_o,
  output logic sync_o,
  output logic busy_o,
  output logic fault_o
);

  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] ON_M1  = CNT_W'(ON_DLY - 1);
  localparam logic [CNT_W-1:0] OFF_M1 = CNT_W'(OFF_DLY - 1);
  localparam logic [CNT_W-1:0] TMO    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_M1 = CNT_W'(TIMEOUT - 1);

  gate_state_t      state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [1:0]       pg_ff;
  logic             pg_s;
  logic             pwr_q, pwr_d;
  logic             sync_q, sync_d;
  logic             busy_q, busy_d;
  logic             fault_q, fault_d;

  assign pg_s = pg_ff[1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pg_ff   <= '0;
      state   <= OFF;
      cnt     <= '0;
      pwr_q   <= 1'b0;
      sync_q  <= 1'b0;
      busy_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      pg_ff   <= {pg_ff[0], pg_i};
      state   <= state_d;
      cnt     <= cnt_d;
      pwr_q   <= pwr_d;
      sync_q  <= sync_d;
      busy_q  <= busy_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    pwr_d   = pwr_q;
    sync_d  = sync_q;
    busy_d  = busy_q;
    fault_d = fault_q;
    unique case (state)
      OFF: begin
        if (en_i) begin
          state_d = RAMP_UP;
          pwr_d   = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      RAMP_UP: begin
        if (cnt != TMO) cnt_d = cnt + ONE;
        // abort outranks both completion and timeout
        if (!en_i) begin
          state_d = RAMP_DN;
          pwr_d   = 1'b0;
          cnt_d   = '0;
        end else if (cnt >= ON_M1 && pg_s) begin
          state_d = ON;
          sync_d  = 1'b1;
          busy_d  = 1'b0;
        end else if (cnt == TMO_M1 && !pg_s) begin
          state_d = FAULT;
          pwr_d   = 1'b0;
          fault_d = 1'b1;
          busy_d  = 1'b0;
        end
      end
      ON: begin
        if (!en_i) begin
          state_d = RAMP_DN;
          pwr_d   = 1'b0;
          sync_d  = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end else if (!pg_s) begin
          state_d = FAULT;
          pwr_d   = 1'b0;
          sync_d  = 1'b0;
          fault_d = 1'b1;
        end
      end
      RAMP_DN: begin
        cnt_d = cnt + ONE;
        if (cnt == OFF_M1) begin
          state_d = OFF;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      FAULT: begin
        pwr_d  = 1'b0;
        sync_d = 1'b0;
        if (!en_i) begin
          state_d = OFF;
          fault_d = 1'b0;
        end
      end
      default: state_d = OFF;
    endcase
  end

  assign pwr_o   = pwr_q;
  assign sync_o  = sync_q;
  assign busy_o  = busy_q;
  assign fault_o = fault_q;

endmodule

// File: rtl/gate_ctrl.sv
// Power-gate responder: N_CH independent enable/sync channels for the startup sequencer.
// Ports: clk_i, rst_i, gate_en_i, gate_pg_i -> gate_pwr_o, gate_sync_o, gate_busy_o, gate_fault_o.
`timescale 1ns/1ps
module gate_ctrl
  import gate_ctrl_pkg::*;
#(
  parameter int unsigned N_CH    = DEF_N_CH,
  parameter int unsigned ON_DLY  = DEF_ON_DLY,
  parameter int unsigned OFF_DLY = DEF_OFF_DLY,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N_CH-1:0] gate_en_i,
  input  logic [N_CH-1:0] gate_pg_i,
  output logic [N_CH-1:0] gate_pwr_o,
  output logic [N_CH-1:0] gate_sync_o,
  output logic [N_CH-1:0] gate_busy_o,
  output logic [N_CH-1:0] gate_fault_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    gate_ctrl_ch #(
      .ON_DLY (ON_DLY),
      .OFF_DLY(OFF_DLY),
      .TIMEOUT(TIMEOUT),
      .CNT_W  (CNT_W)
    ) u_ch (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .en_i   (gate_en_i[g]),
      .pg_i   (gate_pg_i[g]),
      .pwr_o  (gate_pwr_o[g]),
      .sync_o (gate_sync_o[g]),
      .busy_o (gate_busy_o[g]),
      .fault_o(gate_fault_o[g])
    );
  end

endmodule

// File: tb/tb_gate_ctrl.sv
// Bench for gate_ctrl: per-cycle comparison against a behavioural channel model
// plus directed latency checks; pg loops back from pwr with a 3-cycle delay.
`timescale 1ns/1ps
module tb_gate_ctrl;

  localparam int N   = 5;
  localparam int OND = 16;
  localparam int OFD = 8;
  localparam int TMO = 64;

  localparam int M_IDLE = 0;
  localparam int M_UP   = 1;
  localparam int M_ON   = 2;
  localparam int M_DN   = 3;
  localparam int M_FLT  = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] en = '0;
  logic [N-1:0] pg;
  logic [N-1:0] pg_kill = '0;
  logic [N-1:0] pwr, sync, busy, fault;
  logic [N-1:0] d1 = '0, d2 = '0, d3 = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int m_mode [N];
  int m_age [N];
  logic [N-1:0] h0 = '0, h1 = '0;

  always #5 clk = ~clk;

  gate_ctrl #(
    .N_CH   (N),
    .ON_DLY (OND),
    .OFF_DLY(OFD),
    .TIMEOUT(TMO)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .gate_en_i   (en),
    .gate_pg_i   (pg),
    .gate_pwr_o  (pwr),
    .gate_sync_o (sync),
    .gate_busy_o (busy),
    .gate_fault_o(fault)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // analog switch stand-in: pg follows pwr three cycles later
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      d1 <= '0; d2 <= '0; d3 <= '0;
    end else begin
      d1 <= pwr; d2 <= d1; d3 <= d2;
    end
  end
  assign pg = d3 & ~pg_kill;

  // behavioural model: age counts edges spent in the current ramp
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_mode[i] <= M_IDLE;
        m_age[i]  <= 0;
      end
      h0 <= '0;
      h1 <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        int md, ag;
        bit p, e;
        md = m_mode[i];
        ag = m_age[i];
        p  = h1[i];
        e  = en[i];
        case (md)
          M_IDLE: if (e) begin md = M_UP; ag = 0; end
          M_UP: begin
            ag = ag + 1;
            if (!e) begin md = M_DN; ag = 0; end
            else if (p && ag >= OND) md = M_ON;
            else if (!p && ag == TMO) md = M_FLT;
          end
          M_ON: begin
            if (!e) begin md = M_DN; ag = 0; end
            else if (!p) md = M_FLT;
          end
          M_DN: begin
            ag = ag + 1;
            if (ag == OFD) begin md = M_IDLE; ag = 0; end
          end
          default: if (!e) md = M_IDLE;
        endcase
        m_mode[i] <= md;
        m_age[i]  <= ag;
      end
      h1 <= h0;
      h0 <= pg;
    end
  end

  task automatic chk(input string nm, input logic [N-1:0] act,
                     input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%b required=%b", nm, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [N-1:0] ep, es, eb, ef;
    for (int i = 0; i < N; i++) begin
      ep[i] = (m_mode[i] == M_UP) || (m_mode[i] == M_ON);
      es[i] = (m_mode[i] == M_ON);
      eb[i] = (m_mode[i] == M_UP) || (m_mode[i] == M_DN);
      ef[i] = (m_mode[i] == M_FLT);
    end
    chk("model_pwr", pwr, ep);
    chk("model_sync", sync, es);
    chk("model_busy", busy, eb);
    chk("model_fault", fault, ef);
  end

  function automatic bit obs(input int sel, input int ch);
    case (sel)
      0: return pwr[ch];
      1: return sync[ch];
      default: return fault[ch];
    endcase
  endfunction

  task automatic wait_bit(input int sel, input int ch, input bit val,
                          input int budget, output int at);
    at = -1;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (obs(sel, ch) == val) begin
        at = cyc;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL wait_timeout sel=%0d ch=%0d val=%0b", sel, ch, val);
  endtask

  initial begin
    int ts, tp, tq, tf, tprev;
    repeat (3) @(negedge clk);
    chk("rst_pwr", pwr, 5'b00000);
    chk("rst_sync", sync, 5'b00000);
    chk("rst_busy", busy, 5'b00000);
    chk("rst_fault", fault, 5'b00000);
    rst = 1'b0;

    // 1: single channel bring-up
    @(negedge clk);
    en[0] = 1'b1;
    ts = cyc;
    wait_bit(0, 0, 1'b1, 5, tp);
    chk_int("t1_pwr_lat", tp - ts, 1);
    wait_bit(1, 0, 1'b1, 40, tq);
    chk_int("t1_sync_lat", tq - tp, 16);
    chk("t1_others", pwr & 5'b11110, 5'b00000);

    // 2: sequencer-style loopback, next channel after previous sync
    tprev = tq;
    for (int ch = 1; ch < N; ch++) begin
      en[ch] = 1'b1;
      wait_bit(0, ch, 1'b1, 5, tp);
      chk_int("t2_order", (tp > tprev) ? 1 : 0, 1);
      wait_bit(1, ch, 1'b1, 40, tq);
      chk_int("t2_sync_lat", tq - tp, 16);
      tprev = tq;
    end
    chk("t2_all_sync", sync, 5'b11111);
    @(negedge clk);
    en = '0;
    repeat (12) @(negedge clk);
    chk("t2_idle_busy", busy, 5'b00000);

    // 3: pg never arrives -> timeout fault
    pg_kill[1] = 1'b1;
    en[1] = 1'b1;
    wait_bit(0, 1, 1'b1, 5, tp);
    wait_bit(2, 1, 1'b1, 80, tf);
    chk_int("t3_fault_lat", tf - tp, 64);
    chk("t3_pwr_off", pwr & 5'b00010, 5'b00000);
    en[1] = 1'b0;
    ts = cyc;
    wait_bit(2, 1, 1'b0, 5, tf);
    chk_int("t3_clear_lat", tf - ts, 1);
    pg_kill[1] = 1'b0;
    repeat (2) @(negedge clk);

    // 4: abort at ramp cycle 5, immediate re-request
    en[2] = 1'b1;
    wait_bit(0, 2, 1'b1, 5, tp);
    repeat (4) @(negedge clk);
    en[2] = 1'b0;
    @(negedge clk);
    chk("t4_pwr_drop", pwr & 5'b00100, 5'b00000);
    chk("t4_no_sync", sync & 5'b00100, 5'b00000);
    en[2] = 1'b1;
    wait_bit(0, 2, 1'b1, 20, tq);
    chk_int("t4_off_hold", tq - (tp + 5), 9);
    wait_bit(1, 2, 1'b1, 40, tq);
    en[2] = 1'b0;
    repeat (12) @(negedge clk);

    // 5: pg loss while ON
    en[3] = 1'b1;
    wait_bit(1, 3, 1'b1, 40, tq);
    @(negedge clk);
    pg_kill[3] = 1'b1;
    ts = cyc;
    wait_bit(2, 3, 1'b1, 10, tf);
    chk_int("t5_fault_lat", tf - ts, 3);
    chk("t5_sync_off", sync & 5'b01000, 5'b00000);
    en[3] = 1'b0;
    @(negedge clk);
    pg_kill[3] = 1'b0;
    repeat (3) @(negedge clk);

    // 6: asynchronous reset during ramp-up
    en = '1;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2;
    chk("t6_busy_pre", busy, 5'b11111);
    #1 rst = 1'b1;
    #1;
    chk("t6_pwr", pwr, 5'b00000);
    chk("t6_sync", sync, 5'b00000);
    chk("t6_busy", busy, 5'b00000);
    chk("t6_fault", fault, 5'b00000);
    @(negedge clk);
    en = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_post_pwr", pwr, 5'b00000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
